// File: rtl/keep_one_in_n_rate_ctrl.sv
// Rate-change sequencer for the keep-one-in-N decimator: defers N updates to packet boundaries.
// Optional forced-apply timeout and sticky err output: define RATE_CTRL_TIMEOUT_EN.
module keep_one_in_n_rate_ctrl #(
  parameter int WIDTH        = 32,
  parameter int MAX_N        = 65535,
  parameter int DEFAULT_N    = 1,
  parameter int DRAIN_CYCLES = 2,
  parameter int HOLD_CYCLES  = 2,
  parameter int TIMEOUT      = 4096,
  localparam int NW          = $clog2(MAX_N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [NW-1:0]    cfg_n,
  output logic [NW-1:0]    n,
  output logic             dec_clear,
  output logic             busy,
  output logic [15:0]      upd_count,
`ifdef RATE_CTRL_TIMEOUT_EN
  output logic             err,
`endif
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  localparam logic [NW-1:0] MAX_N_W     = NW'(MAX_N);
  localparam logic [NW-1:0] DEFAULT_N_W = NW'(DEFAULT_N);
  localparam int            CMAX        = (DRAIN_CYCLES > HOLD_CYCLES) ? DRAIN_CYCLES : HOLD_CYCLES;
  localparam int            CW          = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PENDING,
    S_DRAIN,
    S_APPLY,
    S_HOLD
  } state_t;

  state_t          r_state;
  logic            r_in_pkt;
  logic            r_pend;
  logic [NW-1:0]   r_pend_n;
  logic [NW-1:0]   r_n;
  logic            r_dec_clear;
  logic [15:0]     r_upd_count;
  logic [CW-1:0]   r_cnt;

  logic            w_gate;
  logic            w_accept;
  logic [NW-1:0]   w_cfg_n_clamped;
  logic            w_req;
  logic            w_pend_any;
  logic            w_boundary;
  logic [NW-1:0]   w_apply_n;

  assign w_gate   = (r_state == S_DRAIN) || (r_state == S_APPLY) || (r_state == S_HOLD);
  assign o_tdata  = i_tdata;
  assign o_tlast  = i_tlast;
  assign o_tvalid = i_tvalid & ~w_gate;
  assign i_tready = o_tready & ~w_gate;
  assign w_accept = i_tvalid & o_tready & ~w_gate;

  assign w_cfg_n_clamped = (cfg_n > MAX_N_W) ? MAX_N_W : cfg_n;
  // A request matching the live N with nothing queued is a no-op.
  assign w_req      = cfg_valid & ~(~r_pend & (w_cfg_n_clamped == r_n));
  assign w_pend_any = r_pend | w_req;
  // A beat accepted this cycle decides the boundary; otherwise the tracked packet state does.
  assign w_boundary = w_accept ? i_tlast : ~r_in_pkt;
  // Fold in a request landing on the last drain cycle so it is not lost when pend clears.
  assign w_apply_n  = w_req ? w_cfg_n_clamped : r_pend_n;

  assign n         = r_n;
  assign dec_clear = r_dec_clear;
  assign upd_count = r_upd_count;
  assign busy      = r_pend | (r_state != S_IDLE);

`ifdef RATE_CTRL_TIMEOUT_EN
  logic [15:0] r_timer;
  logic        r_err;
  assign err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_pkt    <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_n    <= DEFAULT_N_W;
      r_n         <= DEFAULT_N_W;
      r_dec_clear <= 1'b0;
      r_upd_count <= 16'd0;
      r_cnt       <= '0;
`ifdef RATE_CTRL_TIMEOUT_EN
      r_timer     <= 16'd0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_dec_clear <= 1'b0;

      if (w_accept) r_in_pkt <= ~i_tlast;

      if (w_req) begin
        r_pend   <= 1'b1;
        r_pend_n <= w_cfg_n_clamped;
      end else if (r_state == S_APPLY) begin
        r_pend <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pend_any) begin
            if (w_boundary) begin
              r_state <= S_DRAIN;
              r_cnt   <= '0;
            end else begin
              r_state <= S_PENDING;
`ifdef RATE_CTRL_TIMEOUT_EN
              r_timer <= 16'd0;
`endif
            end
          end
        end
        S_PENDING: begin
          if (w_accept && i_tlast) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
          end
`ifdef RATE_CTRL_TIMEOUT_EN
          else if (r_timer == 16'(TIMEOUT - 1)) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
            r_err   <= 1'b1;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
`endif
        end
        S_DRAIN: begin
          if (r_cnt == CW'(DRAIN_CYCLES - 1)) begin
            r_state     <= S_APPLY;
            r_n         <= w_apply_n;
            r_dec_clear <= 1'b1;
            r_upd_count <= r_upd_count + 16'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_APPLY: begin
          r_state <= S_HOLD;
          r_cnt   <= '0;
        end
        S_HOLD: begin
          if (r_cnt == CW'(HOLD_CYCLES - 1)) r_state <= S_IDLE;
          else                               r_cnt   <= r_cnt + CW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keep_one_in_n_rate_ctrl.sv
// Directed self-checking bench for keep_one_in_n_rate_ctrl (timeout steps need RATE_CTRL_TIMEOUT_EN).
module tb_keep_one_in_n_rate_ctrl;

  localparam int WIDTH   = 32;
  localparam int MAX_N   = 40000;
  localparam int NW      = $clog2(MAX_N + 1);
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid;
  logic [NW-1:0]    cfg_n;
  logic [NW-1:0]    n;
  logic             dec_clear;
  logic             busy;
  logic [15:0]      upd_count;
  logic [WIDTH-1:0] i_tdata;
  logic             i_tlast;
  logic             i_tvalid;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;
`ifdef RATE_CTRL_TIMEOUT_EN
  logic             err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  keep_one_in_n_rate_ctrl #(
    .WIDTH(WIDTH), .MAX_N(MAX_N), .DEFAULT_N(1),
    .DRAIN_CYCLES(2), .HOLD_CYCLES(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_n(cfg_n),
    .n(n), .dec_clear(dec_clear), .busy(busy), .upd_count(upd_count),
`ifdef RATE_CTRL_TIMEOUT_EN
    .err(err),
`endif
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_n = '0;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    ticks(2);
    reset = 1'b0;
    tick();

    // Reset state and plain pass-through.
    check("rst_n", 32'(n), 32'd1);
    check("rst_dec_clear", 32'(dec_clear), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_upd_count", 32'(upd_count), 32'd0);
    i_tvalid = 1'b1; i_tdata = 32'hA5A5_0001; i_tlast = 1'b1;
    #1;
    check("pass_tvalid", 32'(o_tvalid), 32'd1);
    check("pass_tdata", o_tdata, 32'hA5A5_0001);
    check("pass_tlast", 32'(o_tlast), 32'd1);
    o_tready = 1'b0;
    #1;
    check("pass_tready_low", 32'(i_tready), 32'd0);
    o_tready = 1'b1; i_tvalid = 1'b0; i_tlast = 1'b0;

    // Idle stream, request N=4: gate 2 cycles, apply, hold 2, resume.
    cfg_valid = 1'b1; cfg_n = 16'd4;
    tick();
    cfg_valid = 1'b0;
    check("idle_drain0_tready", 32'(i_tready), 32'd0);
    check("idle_drain0_busy", 32'(busy), 32'd1);
    check("idle_drain0_n", 32'(n), 32'd1);
    tick();
    check("idle_drain1_tready", 32'(i_tready), 32'd0);
    check("idle_drain1_clr", 32'(dec_clear), 32'd0);
    tick();
    check("idle_apply_n", 32'(n), 32'd4);
    check("idle_apply_clr", 32'(dec_clear), 32'd1);
    check("idle_apply_upd", 32'(upd_count), 32'd1);
    check("idle_apply_tready", 32'(i_tready), 32'd0);
    tick();
    check("idle_hold0_clr", 32'(dec_clear), 32'd0);
    check("idle_hold0_tready", 32'(i_tready), 32'd0);
    tick();
    check("idle_hold1_busy", 32'(busy), 32'd1);
    tick();
    check("idle_resume_tready", 32'(i_tready), 32'd1);
    check("idle_resume_busy", 32'(busy), 32'd0);

    // Mid-packet request for N=8 on beat 3 of 8: every beat passes, change after tlast.
    for (int b = 0; b < 8; b++) begin
      i_tvalid = 1'b1; i_tdata = 32'h100 + 32'(b); i_tlast = (b == 7);
      cfg_valid = (b == 2); cfg_n = 16'd8;
      #1;
      check($sformatf("pkt_beat%0d_tvalid", b), 32'(o_tvalid), 32'd1);
      check($sformatf("pkt_beat%0d_tdata", b), o_tdata, 32'h100 + 32'(b));
      tick();
      cfg_valid = 1'b0;
      if (b < 7) check($sformatf("pkt_beat%0d_n", b), 32'(n), 32'd4);
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
    check("pkt_drain_tready", 32'(i_tready), 32'd0);
    check("pkt_drain_n", 32'(n), 32'd4);
    ticks(2);
    check("pkt_apply_n", 32'(n), 32'd8);
    check("pkt_apply_clr", 32'(dec_clear), 32'd1);
    check("pkt_apply_upd", 32'(upd_count), 32'd2);
    ticks(3);
    check("pkt_idle_busy", 32'(busy), 32'd0);

    // Two requests (3 then 5) inside one packet: single apply with the last one.
    i_tvalid = 1'b1; i_tlast = 1'b0;
    tick();
    i_tvalid = 1'b0;
    cfg_valid = 1'b1; cfg_n = 16'd3;
    tick();
    check("two_pending_tready", 32'(i_tready), 32'd1);
    cfg_n = 16'd5;
    tick();
    cfg_valid = 1'b0;
    i_tvalid = 1'b1; i_tlast = 1'b1;
    tick();
    i_tvalid = 1'b0; i_tlast = 1'b0;
    check("two_drain_tready", 32'(i_tready), 32'd0);
    ticks(2);
    check("two_apply_n", 32'(n), 32'd5);
    check("two_apply_clr", 32'(dec_clear), 32'd1);
    check("two_apply_upd", 32'(upd_count), 32'd3);
    ticks(3);
    check("two_idle_busy", 32'(busy), 32'd0);
    check("two_idle_upd", 32'(upd_count), 32'd3);

    // Request above MAX_N clamps to MAX_N.
    cfg_valid = 1'b1; cfg_n = 16'd50000;
    tick();
    cfg_valid = 1'b0;
    ticks(2);
    check("clamp_n", 32'(n), 32'd40000);
    check("clamp_upd", 32'(upd_count), 32'd4);
    ticks(3);

    // Request equal to current N while idle is ignored.
    cfg_valid = 1'b1; cfg_n = 16'd40000;
    tick();
    cfg_valid = 1'b0;
    check("same_busy0", 32'(busy), 32'd0);
    check("same_tready0", 32'(i_tready), 32'd1);
    tick();
    check("same_busy1", 32'(busy), 32'd0);
    check("same_clr1", 32'(dec_clear), 32'd0);
    check("same_upd", 32'(upd_count), 32'd4);

    // Mid-packet, request arrives with the tlast beat: straight to drain; N=0 (pass-all).
    i_tvalid = 1'b1; i_tlast = 1'b0;
    tick();
    i_tlast = 1'b1; cfg_valid = 1'b1; cfg_n = 16'd0;
    tick();
    cfg_valid = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0;
    check("lastbeat_drain_tready", 32'(i_tready), 32'd0);
    ticks(2);
    check("lastbeat_apply_n", 32'(n), 32'd0);
    check("lastbeat_apply_upd", 32'(upd_count), 32'd5);
    ticks(3);
    check("lastbeat_idle_busy", 32'(busy), 32'd0);

`ifdef RATE_CTRL_TIMEOUT_EN
    // Stalled packet: forced drain after TIMEOUT cycles in PENDING, sticky err.
    i_tvalid = 1'b1; i_tlast = 1'b0;
    tick();
    i_tvalid = 1'b0;
    cfg_valid = 1'b1; cfg_n = 16'd7;
    tick();
    cfg_valid = 1'b0;
    ticks(TIMEOUT - 1);
    check("to_pending_tready", 32'(i_tready), 32'd1);
    check("to_pending_err", 32'(err), 32'd0);
    tick();
    check("to_drain_tready", 32'(i_tready), 32'd0);
    check("to_drain_err", 32'(err), 32'd1);
    ticks(2);
    check("to_apply_n", 32'(n), 32'd7);
    ticks(8);
    check("to_err_sticky", 32'(err), 32'd1);
`endif

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst2_n", 32'(n), 32'd1);
    check("rst2_upd", 32'(upd_count), 32'd0);
`ifdef RATE_CTRL_TIMEOUT_EN
    check("rst2_err", 32'(err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
